// File: rtl/datapath_stack_pkg.sv
// Shared encodings for the datapath_stack slice: register-file write-source
// selects, ALU operation codes and the default pc increment.
package datapath_stack_pkg;

  localparam int unsigned RF_SRC_W = 3;
  localparam int unsigned ALU_OP_W = 3;

  // Register-file write source (rfSrc)
  localparam logic [RF_SRC_W-1:0] RF_SRC_ZERO = 3'd0;
  localparam logic [RF_SRC_W-1:0] RF_SRC_RB   = 3'd1;
  localparam logic [RF_SRC_W-1:0] RF_SRC_ALU  = 3'd2;
  localparam logic [RF_SRC_W-1:0] RF_SRC_MEM  = 3'd3;
  localparam logic [RF_SRC_W-1:0] RF_SRC_IN   = 3'd4;
  localparam logic [RF_SRC_W-1:0] RF_SRC_IMM  = 3'd5;
  localparam logic [RF_SRC_W-1:0] RF_SRC_LINK = 3'd6;

  // ALU operation (aluOp)
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'd7;

  localparam int unsigned PC_STEP_DEFAULT = 2;

endpackage

// File: rtl/datapath_link_stack.sv
// Circular return-address stack for call/return.
// Ports: clk/rst (sync, active-low); push/pop requests (already qualified by
// commit); pushData in; top out (0 when empty); empty/full status;
// overflow/underflow sticky flags cleared only by reset.
module datapath_link_stack
  import datapath_stack_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] pushData,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = (LS_DEPTH > 1) ? $clog2(LS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LS_DEPTH - 1);

  logic [DATA_W-1:0] mem_q [LS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, wr_en;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(LS_DEPTH));
  assign top       = empty ? '0 : mem_q[ptr_q];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // ptr_q always indexes the top entry; pointers wrap at LS_DEPTH
  assign ptr_inc = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? LAST : ptr_q - PTR_W'(1);

  // Pointer/count/flag update for the four push/pop combinations
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) begin
        // nothing to pop: flag it, the push still lands
        unf_d  = 1'b1;
        ptr_d  = ptr_inc;
        wr_idx = ptr_inc;
        cnt_d  = CNT_W'(1);
      end
      // non-empty: top replaced in place, depth unchanged
    end else if (push) begin
      wr_en  = 1'b1;
      ptr_d  = ptr_inc;
      wr_idx = ptr_inc;
      // when full, ptr_inc lands on the oldest entry and overwrites it
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_idx] <= pushData;
  end

endmodule

// File: rtl/datapath_stack.sv
// Single-cycle datapath with register file, ALU, Z/N flags, output port,
// link stack for call/return and a ready-handshaked data-memory port.
// Ports: control inputs from the decoder (rfSrc, aluOp, branch, branchIf,
// call, ret, rfWrite, outWrite, zWrite, nWrite, memRead, memWrite); instr
// and pc to instruction memory; fromDataMemory/memReady and
// toDataMemoryAddress/toDataMemory/memReq/memWe to data memory;
// fromInputPort/toOutputPort I/O; stall and sticky lsOverflow/lsUnderflow.
module datapath_stack
  import datapath_stack_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REG_AW   = 2,
  parameter int unsigned LS_DEPTH = 4,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RF_SRC_W-1:0] rfSrc,
  input  logic [ALU_OP_W-1:0] aluOp,
  input  logic                branch,
  input  logic                branchIf,
  input  logic                call,
  input  logic                ret,
  input  logic                rfWrite,
  input  logic                outWrite,
  input  logic                zWrite,
  input  logic                nWrite,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [DATA_W+7:0]   instr,
  input  logic [DATA_W-1:0]   fromInputPort,
  input  logic [DATA_W-1:0]   fromDataMemory,
  input  logic                memReady,
  output logic [DATA_W-1:0]   pc,
  output logic [DATA_W-1:0]   toOutputPort,
  output logic [DATA_W-1:0]   toDataMemoryAddress,
  output logic [DATA_W-1:0]   toDataMemory,
  output logic                memReq,
  output logic                memWe,
  output logic                stall,
  output logic                lsOverflow,
  output logic                lsUnderflow
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] pc_q, pc_d, pc_inc, out_q;
  logic              z_q, n_q;

  logic [DATA_W-1:0] imm, ra_data, rb_data, alu_res, wr_data;
  logic [REG_AW-1:0] ra_idx, rb_idx;
  logic              brx, alu_z, alu_n, taken, commit;
  logic [DATA_W-1:0] ls_top;
  logic              ls_empty, ls_full_unused, instr_unused;

  // Instruction fields
  assign imm          = instr[DATA_W+7:8];
  assign brx          = instr[7];
  assign ra_idx       = instr[2*REG_AW-1:REG_AW];
  assign rb_idx       = instr[REG_AW-1:0];
  assign instr_unused = ^instr[6:2*REG_AW];

  assign ra_data = rf_q[ra_idx];
  assign rb_data = rf_q[rb_idx];

  // Memory handshake: the instruction is held until memReady
  assign memReq = rst & (memRead | memWrite);
  assign memWe  = memReq & memWrite;
  assign stall  = memReq & ~memReady;
  assign commit = ~stall;

  assign toDataMemoryAddress = imm;
  assign toDataMemory        = ra_data;
  assign pc                  = pc_q;
  assign toOutputPort        = out_q;

  // ALU
  always_comb begin
    alu_res = '0;
    case (aluOp)
      ALU_ADD: alu_res = ra_data + rb_data;
      ALU_SUB: alu_res = ra_data - rb_data;
      ALU_AND: alu_res = ra_data & rb_data;
      ALU_OR:  alu_res = ra_data | rb_data;
      ALU_XOR: alu_res = ra_data ^ rb_data;
      ALU_NOT: alu_res = ~ra_data;
      ALU_SHL: alu_res = ra_data << 1;
      ALU_SHR: alu_res = ra_data >> 1;
      default: alu_res = '0;
    endcase
  end
  assign alu_z = (alu_res == '0);
  assign alu_n = alu_res[DATA_W-1];

  // Register write source
  always_comb begin
    wr_data = '0;
    case (rfSrc)
      RF_SRC_ZERO: wr_data = '0;
      RF_SRC_RB:   wr_data = rb_data;
      RF_SRC_ALU:  wr_data = alu_res;
      RF_SRC_MEM:  wr_data = fromDataMemory;
      RF_SRC_IN:   wr_data = fromInputPort;
      RF_SRC_IMM:  wr_data = imm;
      RF_SRC_LINK: wr_data = ls_top;
      default:     wr_data = '0;
    endcase
  end

  // Branch decision uses flags from before this instruction
  assign taken  = branch & (~branchIf | (brx ? n_q : z_q));
  assign pc_inc = pc_q + DATA_W'(PC_STEP);

  // Next pc: ret beats call/branch; empty-stack ret falls through
  always_comb begin
    pc_d = pc_inc;
    if (ret) begin
      pc_d = ls_empty ? pc_inc : ls_top;
    end else if (call || taken) begin
      pc_d = imm;
    end
  end

  datapath_link_stack #(
    .DATA_W  (DATA_W),
    .LS_DEPTH(LS_DEPTH)
  ) u_link_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (commit & call),
    .pop      (commit & ret),
    .pushData (pc_inc),
    .top      (ls_top),
    .empty    (ls_empty),
    .full     (ls_full_unused),
    .overflow (lsOverflow),
    .underflow(lsUnderflow)
  );

  // Architectural state; reset wins over a pending stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      out_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (commit) begin
      pc_q <= pc_d;
      if (zWrite)   z_q   <= alu_z;
      if (nWrite)   n_q   <= alu_n;
      if (outWrite) out_q <= ra_data;
      if (rfWrite)  rf_q[ra_idx] <= wr_data;
    end
  end

endmodule

// File: doc/datapath_stack.md
Name: datapath_stack

Overview:
- Parametrised next-generation single-cycle datapath: configurable data width and register count, a hardware link stack of configurable depth for nested call/return, and a ready-handshaked data-memory port that stalls the instruction until the memory responds.
- Sits between the control decoder (drives all control inputs from the current instruction), instruction memory (pc/instr), data memory and the I/O ports.

Parameters:
DATA_W, 8, datapath, register, immediate, pc and port width
REG_AW, 2, register-address bits; register count = 2**REG_AW; legal range 1..3
LS_DEPTH, 4, link-stack entries (>=1)
PC_STEP, 2, pc increment per committed instruction

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
rfSrc  in  3  register-write source select
aluOp  in  3  ALU operation
branch  in  1  branch instruction
branchIf  in  1  conditional branch (else unconditional)
call  in  1  push pc+PC_STEP, jump to imm
ret  in  1  pop link stack into pc
rfWrite  in  1  write register ra
outWrite  in  1  load output port from ra
zWrite  in  1  update Z flag
nWrite  in  1  update N flag
memRead  in  1  data-memory read
memWrite  in  1  data-memory write
instr  in  DATA_W+8  current instruction
fromInputPort  in  DATA_W  input port
fromDataMemory  in  DATA_W  read data, valid when memReady=1
memReady  in  1  memory completes the request this cycle
pc  out  DATA_W  instruction address
toOutputPort  out  DATA_W  registered output port
toDataMemoryAddress  out  DATA_W  = imm
toDataMemory  out  DATA_W  = register ra data
memReq  out  1  memory request
memWe  out  1  request is a write
stall  out  1  instruction held this cycle
lsOverflow  out  1  sticky: push onto a full stack
lsUnderflow  out  1  sticky: pop from an empty stack

Behaviour:
- Fields: imm = instr[DATA_W+7:8]; brx = instr[7]; ra = instr[2*REG_AW-1:REG_AW]; rb = instr[REG_AW-1:0].
- Reset (rst=0 at rising edge): pc=0, all registers=0, Z=N=0, toOutputPort=0, link stack empty, both sticky flags 0. memReq=0 while rst=0. Reset overrides everything, including a stalled request.
- memReq = rst & (memRead|memWrite); memWe = memReq & memWrite; stall = memReq & ~memReady.
- commit = ~stall. With no memory op, every instruction commits in 1 cycle. With a memory op, it commits in the cycle memReady=1; memory latency is unbounded.
- While stalled: pc, registers, flags, output port and link stack hold. Outputs and memReq stay stable (instr is held by the controller).
- ALU (DATA_W, modulo 2**DATA_W), A=ra data, B=rb data: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 A<<1, 7 A>>1 logical. aluZ = (result==0); aluN = result MSB. Z/N load on commit when zWrite/nWrite.
- Register write on commit when rfWrite, to ra. Source by rfSrc: 1 rb data, 2 ALU, 3 fromDataMemory, 4 fromInputPort, 5 imm, 6 link-stack top (0 if empty), 0/7 zero. Reads are combinational; a write is visible next cycle.
- Branch taken = branch & (~branchIf | (brx ? N : Z)), using the registered flags before this instruction's update.
- Next pc on commit, by priority: ret → top of stack (pc+PC_STEP if empty); call or taken branch → imm; else pc+PC_STEP. Modulo 2**DATA_W.
- Link stack:
  - call pushes pc+PC_STEP.
  - Full + call: the oldest entry is discarded (circular) and lsOverflow is set.
  - Empty + ret: no pop, and lsUnderflow is set.
  - call & ret together, non-empty: pc ← top, top replaced by pc+PC_STEP, depth unchanged.
  - call & ret together, empty: underflow is flagged, push proceeds, pc ← pc+PC_STEP.
- Sticky flags clear only on reset.

Decomposition:
- Shared package: rfSrc and aluOp encodings as named constants, PC_STEP default.
- One sub-module, datapath_link_stack (params DATA_W, LS_DEPTH; ports push, pop, pushData, top, empty, full, overflow, underflow), containing the circular buffer, pointer and count.
- ALU and register file stay inline.

Test Plan:
- Reset then rfSrc=5, imm=0x3C, ra=1, rfWrite; then aluOp=0 with r1+r1 into r1 → r1=0x78, Z=0, N=0, pc advances 0→2→4.
- aluOp=1 with r1=r2=0x05, zWrite → Z=1. Conditional branch brx=0 to 0x40 → pc=0x40. Same branch with Z=0 → pc+2.
- call to 0x20 at pc=0x10, nested call at 0x20 to 0x30, ret, ret → pc sequence 0x20, 0x30, 0x22, 0x12; no sticky flags.
- LS_DEPTH=4: five calls then five rets → lsOverflow=1, first four rets return the newest four addresses, fifth ret sets lsUnderflow and pc+=2.
- memRead with memReady low for 3 cycles, then high with fromDataMemory=0xA5 → stall=1 for 3 cycles, pc held, r[ra]=0xA5 after commit.
- Assert rst=0 mid-stall → next cycle pc=0, memReq=0, registers cleared. Also repeat the call/branch scenarios with DATA_W=16, REG_AW=3; the wrap case 0xFFFE+2 → 0x0000.
